nts_tx_mac_dispatcher: RTL and testbench
========================================

# nts_tx_mac_dispatcher

Drains finished NTS response packets out of the engine's double-buffered transmit buffer and presents them to the Ethernet MAC as a 64-bit ready/valid stream. It sits directly downstream of the transmit buffer and consumes its dispatch interface: packet-available, read-enable, read data, empty and bytes-in-last-word. When the MAC has taken the last word, it hands the buffer back with a one-cycle release pulse.

## Interface
- MAX_WORDS, 256: maximum words per packet; exceeding it aborts the packet.
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; one clock, reset is synchronous and active-low.
- i_dispatch_tx_packet_available  in  1  upstream holds a complete packet.
- i_dispatch_tx_fifo_empty  in  1  all words of the current packet have been read.
- o_dispatch_tx_fifo_rd_en  out  1  read one word; data is returned the next cycle.
- i_dispatch_tx_fifo_rd_data  in  64  read data, valid the cycle after rd_en.
- i_dispatch_tx_bytes_last_word  in  4  valid bytes in the last word (1..8).
- o_dispatch_tx_packet_read  out  1  one-cycle release of the upstream packet.
- o_tx_valid  out  1  stream word valid.
- i_tx_ready  in  1  MAC accepts the word.
- o_tx_data  out  64  big-endian; byte 0 is in [63:56].
- o_tx_keep  out  8  byte enables; keep[7] covers [63:56].
- o_tx_last  out  1  last word of the packet.
- o_error  out  1  sticky: bad bytes_last_word or overrun; cleared only by reset.
- o_packets_sent  out  32  count of completed packets; wraps.

## Operation
- States:
  - IDLE: if available=1, go to READ.
  - READ: issue reads; capture the last word; then go to DRAIN.
  - DRAIN: wait for the last word to be accepted; then go to RELEASE.
  - RELEASE: pulse packet_read; go to GAP.
  - GAP: one idle cycle; go to IDLE.
- Outputs come from a 2-entry output FIFO. Each entry holds data, keep and last.
- Read issue, in READ only:
  - rd_en = !fifo_empty && !last_captured && (occupancy + inflight − pop_this_cycle) < 2.
  - inflight is 1 in the cycle after rd_en.
- Capture: in the cycle after rd_en, push {rd_data, keep, last}. last = i_dispatch_tx_fifo_empty sampled in that capture cycle.
- keep: 8'hFF for non-last words.
  - Last word: bytes_last_word n=1..8 gives n leading ones (n=3 → 8'hE0).
  - n=0 or n>8: keep=8'hFF and o_error set.
- Overrun: if MAX_WORDS words are captured without last, force last=1 on that word and set o_error. The packet still drains and releases normally.
- Pop on o_tx_valid && i_tx_ready. The stream holds data/keep/last stable while valid && !ready.
- o_packets_sent increments in the RELEASE cycle.
- rd_en and packet_read are never asserted together. rd_en is never asserted outside READ.

## Timing
- Reset values: o_tx_valid=0, o_tx_data=0, o_tx_keep=0, o_tx_last=0, o_dispatch_tx_fifo_rd_en=0, o_dispatch_tx_packet_read=0, o_error=0, o_packets_sent=0. State resets to IDLE and the output FIFO is emptied.
- Startup latency: available=1 sampled in IDLE at cycle T. Then rd_en at T+1, capture at T+2, first o_tx_valid at T+3.
- Throughput: with i_tx_ready held high, one word per cycle, no bubbles inside a packet.
- Back-to-back packets: packet_read at cycle R, GAP at R+1, IDLE samples available at R+2. Minimum 4 dead cycles between one packet's o_tx_last and the next packet's first valid.
- Backpressure: i_tx_ready low for any length loses no data. At most 2 words are buffered plus 0 in flight.
- Single-word packet: fifo_empty=1 in the capture cycle, so that word carries last=1.
- Reset mid-packet: the packet is abandoned and packet_read is not asserted. The upstream packet stays available and is re-sent from word 0 after reset.

## Structure
- Package nts_tx_pkg: state encoding constants and a keep-from-byte-count function. nts_tx_buffer may share these later.
- One sub-module: nts_tx_skid_fifo (2-entry, 73-bit wide {data, keep, last}, with occupancy output).

## Test plan
- 3-word packet, bytes_last_word=5, ready=1:
  - Words out on consecutive cycles.
  - keep = FF, FF, F8; last only on the 3rd word.
  - packet_read pulses once; o_packets_sent=1.
- Same packet with ready toggling 1,0,0,1,0,1…:
  - Data is identical and in order; no duplicates.
  - rd_en never pushes occupancy+inflight above 2.
- 1-word packet, bytes_last_word=8: one beat with keep=FF and last=1.
- Two packets back-to-back: the second first valid comes ≥4 cycles after the first last; o_packets_sent=2.
- bytes_last_word=0: keep=FF on the last word, o_error=1 and stays 1; a following good packet still sends.
- MAX_WORDS=4 with a 6-word packet: 4 words out, last forced on the 4th, o_error=1, then released. Repeat with i_reset_n low in the middle of the 2nd word: outputs return to reset values, no packet_read, and the packet is re-sent.

Source files
------------

// File: rtl/nts_tx_pkg.sv
// nts_tx_pkg
//   Shared definitions for the NTS transmit path.
//   - tx_state_t      : dispatcher FSM state encoding
//   - tx_entry_t      : one stream beat {data, keep, last} as held in the output FIFO
//   - bytes_valid     : legal range check for a bytes-in-last-word count (1..8)
//   - keep_from_bytes : byte-enable mask with n leading ones, all ones when n is illegal
package nts_tx_pkg;

  localparam int DATA_W  = 64;
  localparam int KEEP_W  = 8;
  localparam int ENTRY_W = DATA_W + KEEP_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4
  } tx_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } tx_entry_t;

  function automatic logic bytes_valid(input logic [3:0] n);
    return (n != 4'd0) && (n <= 4'd8);
  endfunction

  // Byte 0 sits in the top lane, so n valid bytes are the n most significant
  // keep bits. An illegal count falls back to a full word.
  function automatic logic [KEEP_W-1:0] keep_from_bytes(input logic [3:0] n);
    logic [KEEP_W-1:0] k;
    k = 8'hFF;
    if (bytes_valid(n)) begin
      k = 8'hFF << (4'd8 - n);
    end
    return k;
  endfunction

endpackage

// File: rtl/nts_tx_skid_fifo.sv
// nts_tx_skid_fifo
//   Two-entry output buffer between the transmit-buffer read side and the MAC
//   stream. Entry 0 (slot0) is always the head, so the presented beat stays
//   stable until it is popped.
//   Ports:
//     clk, reset_n  : clock, synchronous active-low reset (empties and zeroes)
//     push          : write push_entry this cycle
//     push_entry    : {data, keep, last}
//     pop           : head consumed this cycle (only meaningful while valid)
//     head          : head entry
//     valid         : at least one entry held
//     occupancy     : number of entries held (0..2)
module nts_tx_skid_fifo
  import nts_tx_pkg::*;
#(
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_entry,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       count;

  // Shift-style storage: a pop moves slot1 forward into slot0. The caller
  // never pushes into a full buffer; such a push is dropped rather than
  // overwriting the entry being presented.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            slot0 <= push_entry;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            slot1 <= push_entry;
            count <= 2'd2;
          end
        end
        2'b01: begin
          if (count != 2'd0) begin
            slot0 <= slot1;
            count <= count - 2'd1;
          end
        end
        2'b11: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_entry;
          end else begin
            slot0 <= push_entry;
            count <= 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head      = slot0;
  assign valid     = (count != 2'd0);
  assign occupancy = count;

endmodule

// File: rtl/nts_tx_mac_dispatcher.sv
// nts_tx_mac_dispatcher
//   Reads a finished NTS response packet out of the transmit buffer and
//   streams it to the Ethernet MAC as 64-bit big-endian beats, then hands the
//   buffer back with a one-cycle release pulse.
//   Ports:
//     i_clk, i_reset_n                 : clock, synchronous active-low reset
//     i_dispatch_tx_packet_available   : upstream holds a complete packet
//     i_dispatch_tx_fifo_empty         : every word of the packet has been read
//     o_dispatch_tx_fifo_rd_en         : read one word (data returns next cycle)
//     i_dispatch_tx_fifo_rd_data       : read data, valid the cycle after rd_en
//     i_dispatch_tx_bytes_last_word    : valid bytes in the last word (1..8)
//     o_dispatch_tx_packet_read        : one-cycle release of the upstream packet
//     o_tx_valid/i_tx_ready            : MAC stream handshake
//     o_tx_data/o_tx_keep/o_tx_last    : stream beat; byte 0 in [63:56]
//     o_error                          : sticky bad byte count or overrun
//     o_packets_sent                   : completed packets, wrapping
module nts_tx_mac_dispatcher
  import nts_tx_pkg::*;
#(
  parameter int MAX_WORDS = 256
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_dispatch_tx_packet_available,
  input  logic              i_dispatch_tx_fifo_empty,
  output logic              o_dispatch_tx_fifo_rd_en,
  input  logic [DATA_W-1:0] i_dispatch_tx_fifo_rd_data,
  input  logic [3:0]        i_dispatch_tx_bytes_last_word,
  output logic              o_dispatch_tx_packet_read,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [DATA_W-1:0] o_tx_data,
  output logic [KEEP_W-1:0] o_tx_keep,
  output logic              o_tx_last,
  output logic              o_error,
  output logic [31:0]       o_packets_sent
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  tx_state_t  state;
  logic       inflight;
  logic       last_captured;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] captured;

  tx_entry_t  head;
  tx_entry_t  push_entry;
  logic       head_valid;
  logic [1:0] occupancy;
  logic       pop;
  logic       rd_en;
  logic [2:0] committed;
  logic       overrun;
  logic       capture_last;
  logic       bad_bytes;

  assign pop = head_valid && i_tx_ready;

  // A read is only issued when the word it returns is guaranteed a FIFO slot:
  // words held plus the one in flight, less the beat leaving this cycle, must
  // stay below two. The issue count cap keeps an overlong packet from reading
  // past the word that gets a forced last.
  always_comb begin
    committed = {1'b0, occupancy} + {2'b00, inflight};
    rd_en     = 1'b0;
    if ((state == ST_READ) && !i_dispatch_tx_fifo_empty && !last_captured &&
        (issued < CNT_W'(MAX_WORDS)) && (committed < (3'd2 + {2'b00, pop}))) begin
      rd_en = 1'b1;
    end
  end

  // Capture side. The upstream empty flag in the capture cycle tells us the
  // returning word was the final one. Reaching the word limit without that
  // flag means the packet is too long, so the word is closed off as last.
  always_comb begin
    overrun         = inflight && !i_dispatch_tx_fifo_empty &&
                      (captured == CNT_W'(MAX_WORDS - 1));
    capture_last    = i_dispatch_tx_fifo_empty || overrun;
    bad_bytes       = inflight && i_dispatch_tx_fifo_empty &&
                      !bytes_valid(i_dispatch_tx_bytes_last_word);
    push_entry.data = i_dispatch_tx_fifo_rd_data;
    push_entry.keep = i_dispatch_tx_fifo_empty ?
                      keep_from_bytes(i_dispatch_tx_bytes_last_word) : 8'hFF;
    push_entry.last = capture_last;
  end

  nts_tx_skid_fifo #(
    .WIDTH(ENTRY_W)
  ) u_skid_fifo (
    .clk        (i_clk),
    .reset_n    (i_reset_n),
    .push       (inflight),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .valid      (head_valid),
    .occupancy  (occupancy)
  );

  // Packet sequencing. The release pulse is raised on entry to RELEASE so it
  // is visible for exactly that cycle; the sent counter advances as RELEASE
  // ends. GAP guarantees a dead cycle before the next packet is looked at.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state                     <= ST_IDLE;
      inflight                  <= 1'b0;
      last_captured             <= 1'b0;
      issued                    <= '0;
      captured                  <= '0;
      o_dispatch_tx_packet_read <= 1'b0;
      o_error                   <= 1'b0;
      o_packets_sent            <= 32'd0;
    end else begin
      inflight                  <= rd_en;
      o_dispatch_tx_packet_read <= 1'b0;
      if (bad_bytes || overrun) begin
        o_error <= 1'b1;
      end
      if (rd_en) begin
        issued <= issued + CNT_W'(1);
      end
      if (inflight) begin
        captured <= captured + CNT_W'(1);
        if (capture_last) begin
          last_captured <= 1'b1;
        end
      end
      case (state)
        ST_IDLE: begin
          issued        <= '0;
          captured      <= '0;
          last_captured <= 1'b0;
          if (i_dispatch_tx_packet_available) begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          if (inflight && capture_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && head.last) begin
            state                     <= ST_RELEASE;
            o_dispatch_tx_packet_read <= 1'b1;
          end
        end
        ST_RELEASE: begin
          o_packets_sent <= o_packets_sent + 32'd1;
          state          <= ST_GAP;
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_dispatch_tx_fifo_rd_en = rd_en;
  assign o_tx_valid               = head_valid;
  assign o_tx_data                = head.data;
  assign o_tx_keep                = head.keep;
  assign o_tx_last                = head.last;

endmodule

// File: tb/tb_nts_tx_mac_dispatcher.sv
// tb_nts_tx_mac_dispatcher
//   Directed bench for nts_tx_mac_dispatcher built with MAX_WORDS=4 so the
//   overrun path is reachable with short packets. A background process plays
//   the transmit buffer and the MAC: all inputs change on the falling edge and
//   outputs are sampled 1 time unit later. Scenario tasks queue packets and
//   compare the collected beats against hand-computed values.
module tb_nts_tx_mac_dispatcher;

  localparam int MAXW = 4;

  logic        clk;
  logic        reset_n;
  logic        avail;
  logic        fifo_empty;
  logic        rd_en;
  logic [63:0] rd_data;
  logic [3:0]  blw;
  logic        packet_read;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] tx_data;
  logic [7:0]  tx_keep;
  logic        tx_last;
  logic        error;
  logic [31:0] packets_sent;

  int total;
  int bad;
  int cycle;

  int         q_len[$];
  logic [3:0] q_blw[$];
  logic [7:0] q_id[$];
  int         rd_ptr;
  bit         pending_rd;
  int         reads_done;

  int          ready_mode;
  bit          ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  logic [63:0] b_data[$];
  logic [7:0]  b_keep[$];
  logic        b_last[$];
  int          b_cycle[$];

  int          pr_count;
  int          outstanding;
  bit          flag_outstanding;
  bit          flag_overlap;
  bit          flag_unstable;
  bit          stall_prev;
  logic [72:0] stall_word;

  nts_tx_mac_dispatcher #(
    .MAX_WORDS(MAXW)
  ) dut (
    .i_clk                          (clk),
    .i_reset_n                      (reset_n),
    .i_dispatch_tx_packet_available (avail),
    .i_dispatch_tx_fifo_empty       (fifo_empty),
    .o_dispatch_tx_fifo_rd_en       (rd_en),
    .i_dispatch_tx_fifo_rd_data     (rd_data),
    .i_dispatch_tx_bytes_last_word  (blw),
    .o_dispatch_tx_packet_read      (packet_read),
    .o_tx_valid                     (tx_valid),
    .i_tx_ready                     (tx_ready),
    .o_tx_data                      (tx_data),
    .o_tx_keep                      (tx_keep),
    .o_tx_last                      (tx_last),
    .o_error                        (error),
    .o_packets_sent                 (packets_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] word_of(input logic [7:0] id, input logic [15:0] idx);
    return {8'hA5, id, 16'h0BAD, 16'hC0DE, idx};
  endfunction

  function automatic void drive_upstream();
    avail      = (q_len.size() > 0);
    fifo_empty = 1'b1;
    blw        = 4'd8;
    if (q_len.size() > 0) begin
      fifo_empty = (rd_ptr >= q_len[0]);
      blw        = q_blw[0];
    end
  endfunction

  // Transmit-buffer and MAC model. A read seen in one cycle returns its word
  // (and the updated empty flag) in the next. Reset rewinds the buffer so the
  // held packet is sent again from word 0.
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (!reset_n) begin
        rd_ptr      = 0;
        pending_rd  = 1'b0;
        outstanding = 0;
        stall_prev  = 1'b0;
      end else if (pending_rd) begin
        if (q_len.size() > 0) begin
          rd_data = word_of(q_id[0], 16'(rd_ptr));
        end
        rd_ptr++;
        reads_done++;
        pending_rd = 1'b0;
      end
      drive_upstream();
      tx_ready = (ready_mode == 0) ? 1'b1 : ready_pat[cycle % 6];
      #1;
      if (reset_n) begin
        if (stall_prev && ((tx_valid !== 1'b1) || ({tx_data, tx_keep, tx_last} !== stall_word))) begin
          flag_unstable = 1'b1;
        end
        if ((rd_en === 1'b1) && (packet_read === 1'b1)) begin
          flag_overlap = 1'b1;
        end
        if ((tx_valid === 1'b1) && tx_ready) begin
          b_data.push_back(tx_data);
          b_keep.push_back(tx_keep);
          b_last.push_back(tx_last);
          b_cycle.push_back(cycle);
          outstanding--;
        end
        if (rd_en === 1'b1) begin
          outstanding++;
        end
        if (outstanding > 2) begin
          flag_outstanding = 1'b1;
        end
        pending_rd = (rd_en === 1'b1);
        if (packet_read === 1'b1) begin
          pr_count++;
          if (q_len.size() > 0) begin
            void'(q_len.pop_front());
            void'(q_blw.pop_front());
            void'(q_id.pop_front());
          end
          rd_ptr = 0;
        end
        stall_prev = (tx_valid === 1'b1) && !tx_ready;
        stall_word = {tx_data, tx_keep, tx_last};
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int len, input logic [3:0] nbytes, input logic [7:0] id);
    q_len.push_back(len);
    q_blw.push_back(nbytes);
    q_id.push_back(id);
    drive_upstream();
  endtask

  task automatic clear_run();
    b_data.delete();
    b_keep.delete();
    b_last.delete();
    b_cycle.delete();
    reads_done       = 0;
    flag_outstanding = 1'b0;
    flag_overlap     = 1'b0;
    flag_unstable    = 1'b0;
  endtask

  task automatic wait_release(input int target, output bit ok);
    int n;
    n = 0;
    while ((pr_count < target) && (n < 300)) begin
      wait_cycles(1);
      n++;
    end
    ok = (pr_count >= target);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cycles(3);
    total += 8;
    if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", tx_valid); end
    if (tx_data !== 64'd0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", tx_data); end
    if (tx_keep !== 8'd0) begin bad++; $display("[TB] FAIL reset_keep: got %h want 00", tx_keep); end
    if (tx_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_last: got %b want 0", tx_last); end
    if (rd_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_en: got %b want 0", rd_en); end
    if (packet_read !== 1'b0) begin bad++; $display("[TB] FAIL reset_packet_read: got %b want 0", packet_read); end
    if (error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error: got %b want 0", error); end
    if (packets_sent !== 32'd0) begin bad++; $display("[TB] FAIL reset_packets_sent: got %0d want 0", packets_sent); end
    reset_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_basic();
    logic [7:0] exp_keep [3] = '{8'hFF, 8'hFF, 8'hF8};
    logic       exp_last [3] = '{1'b0, 1'b0, 1'b1};
    int  start;
    bit  ok;
    clear_run();
    start = cycle;
    applyStimulus(3, 4'd5, 8'd1);
    wait_release(1, ok);
    wait_cycles(2);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL basic_release: releases %0d want 1 (timeout)", pr_count); end
    total++;
    if (b_data.size() != 3) begin bad++; $display("[TB] FAIL basic_beats: got %0d want 3", b_data.size()); end
    for (int i = 0; i < 3 && i < b_data.size(); i++) begin
      total += 3;
      if (b_data[i] !== word_of(8'd1, 16'(i))) begin bad++; $display("[TB] FAIL basic_data[%0d]: got %h want %h", i, b_data[i], word_of(8'd1, 16'(i))); end
      if (b_keep[i] !== exp_keep[i]) begin bad++; $display("[TB] FAIL basic_keep[%0d]: got %h want %h", i, b_keep[i], exp_keep[i]); end
      if (b_last[i] !== exp_last[i]) begin bad++; $display("[TB] FAIL basic_last[%0d]: got %b want %b", i, b_last[i], exp_last[i]); end
    end
    if (b_cycle.size() == 3) begin
      total += 2;
      if (b_cycle[0] != start + 3) begin bad++; $display("[TB] FAIL basic_latency: first beat cycle %0d want %0d", b_cycle[0], start + 3); end
      if (b_cycle[2] - b_cycle[0] != 2) begin bad++; $display("[TB] FAIL basic_throughput: span %0d want 2", b_cycle[2] - b_cycle[0]); end
    end
    total += 5;
    if (pr_count != 1) begin bad++; $display("[TB] FAIL basic_pulses: got %0d want 1", pr_count); end
    if (packets_sent !== 32'd1) begin bad++; $display("[TB] FAIL basic_sent: got %0d want 1", packets_sent); end
    if (error !== 1'b0) begin bad++; $display("[TB] FAIL basic_error: got %b want 0", error); end
    if (reads_done != 3) begin bad++; $display("[TB] FAIL basic_reads: got %0d want 3", reads_done); end
    if (flag_overlap) begin bad++; $display("[TB] FAIL basic_overlap: rd_en with packet_read got 1 want 0"); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_keep [3] = '{8'hFF, 8'hFF, 8'hF8};
    logic       exp_last [3] = '{1'b0, 1'b0, 1'b1};
    bit ok;
    clear_run();
    ready_mode = 1;
    applyStimulus(3, 4'd5, 8'd2);
    wait_release(2, ok);
    ready_mode = 0;
    wait_cycles(2);
    total += 2;
    if (!ok) begin bad++; $display("[TB] FAIL bp_release: releases %0d want 2 (timeout)", pr_count); end
    if (b_data.size() != 3) begin bad++; $display("[TB] FAIL bp_beats: got %0d want 3", b_data.size()); end
    for (int i = 0; i < 3 && i < b_data.size(); i++) begin
      total += 3;
      if (b_data[i] !== word_of(8'd2, 16'(i))) begin bad++; $display("[TB] FAIL bp_data[%0d]: got %h want %h", i, b_data[i], word_of(8'd2, 16'(i))); end
      if (b_keep[i] !== exp_keep[i]) begin bad++; $display("[TB] FAIL bp_keep[%0d]: got %h want %h", i, b_keep[i], exp_keep[i]); end
      if (b_last[i] !== exp_last[i]) begin bad++; $display("[TB] FAIL bp_last[%0d]: got %b want %b", i, b_last[i], exp_last[i]); end
    end
    total += 4;
    if (flag_outstanding) begin bad++; $display("[TB] FAIL bp_outstanding: above 2 got 1 want 0"); end
    if (flag_unstable) begin bad++; $display("[TB] FAIL bp_stable: changed while stalled got 1 want 0"); end
    if (flag_overlap) begin bad++; $display("[TB] FAIL bp_overlap: rd_en with packet_read got 1 want 0"); end
    if (packets_sent !== 32'd2) begin bad++; $display("[TB] FAIL bp_sent: got %0d want 2", packets_sent); end
  endtask

  task automatic test_single_word();
    bit ok;
    clear_run();
    applyStimulus(1, 4'd8, 8'd3);
    wait_release(3, ok);
    wait_cycles(2);
    total += 3;
    if (!ok) begin bad++; $display("[TB] FAIL single_release: releases %0d want 3 (timeout)", pr_count); end
    if (b_data.size() != 1) begin bad++; $display("[TB] FAIL single_beats: got %0d want 1", b_data.size()); end
    if (packets_sent !== 32'd3) begin bad++; $display("[TB] FAIL single_sent: got %0d want 3", packets_sent); end
    if (b_data.size() == 1) begin
      total += 3;
      if (b_data[0] !== word_of(8'd3, 16'd0)) begin bad++; $display("[TB] FAIL single_data: got %h want %h", b_data[0], word_of(8'd3, 16'd0)); end
      if (b_keep[0] !== 8'hFF) begin bad++; $display("[TB] FAIL single_keep: got %h want ff", b_keep[0]); end
      if (b_last[0] !== 1'b1) begin bad++; $display("[TB] FAIL single_last: got %b want 1", b_last[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_data [5];
    logic [7:0]  exp_keep [5] = '{8'hFF, 8'hF0, 8'hFF, 8'hFF, 8'h80};
    logic        exp_last [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit ok;
    exp_data[0] = word_of(8'd4, 16'd0);
    exp_data[1] = word_of(8'd4, 16'd1);
    exp_data[2] = word_of(8'd5, 16'd0);
    exp_data[3] = word_of(8'd5, 16'd1);
    exp_data[4] = word_of(8'd5, 16'd2);
    clear_run();
    applyStimulus(2, 4'd4, 8'd4);
    applyStimulus(3, 4'd1, 8'd5);
    wait_release(5, ok);
    wait_cycles(2);
    total += 3;
    if (!ok) begin bad++; $display("[TB] FAIL b2b_release: releases %0d want 5 (timeout)", pr_count); end
    if (b_data.size() != 5) begin bad++; $display("[TB] FAIL b2b_beats: got %0d want 5", b_data.size()); end
    if (packets_sent !== 32'd5) begin bad++; $display("[TB] FAIL b2b_sent: got %0d want 5", packets_sent); end
    for (int i = 0; i < 5 && i < b_data.size(); i++) begin
      total += 3;
      if (b_data[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", i, b_data[i], exp_data[i]); end
      if (b_keep[i] !== exp_keep[i]) begin bad++; $display("[TB] FAIL b2b_keep[%0d]: got %h want %h", i, b_keep[i], exp_keep[i]); end
      if (b_last[i] !== exp_last[i]) begin bad++; $display("[TB] FAIL b2b_last[%0d]: got %b want %b", i, b_last[i], exp_last[i]); end
    end
    if (b_cycle.size() == 5) begin
      total++;
      if (b_cycle[2] - b_cycle[1] < 5) begin bad++; $display("[TB] FAIL b2b_gap: last-to-first %0d cycles want >= 5", b_cycle[2] - b_cycle[1]); end
    end
  endtask

  task automatic test_bad_bytes();
    bit ok;
    clear_run();
    applyStimulus(2, 4'd0, 8'd6);
    applyStimulus(1, 4'd3, 8'd7);
    wait_release(6, ok);
    wait_cycles(1);
    total += 2;
    if (!ok) begin bad++; $display("[TB] FAIL badb_release1: releases %0d want 6 (timeout)", pr_count); end
    if (error !== 1'b1) begin bad++; $display("[TB] FAIL badb_error_set: got %b want 1", error); end
    wait_release(7, ok);
    wait_cycles(2);
    total += 4;
    if (!ok) begin bad++; $display("[TB] FAIL badb_release2: releases %0d want 7 (timeout)", pr_count); end
    if (b_data.size() != 3) begin bad++; $display("[TB] FAIL badb_beats: got %0d want 3", b_data.size()); end
    if (error !== 1'b1) begin bad++; $display("[TB] FAIL badb_error_sticky: got %b want 1", error); end
    if (packets_sent !== 32'd7) begin bad++; $display("[TB] FAIL badb_sent: got %0d want 7", packets_sent); end
    if (b_data.size() == 3) begin
      total += 5;
      if (b_keep[1] !== 8'hFF) begin bad++; $display("[TB] FAIL badb_keep_bad: got %h want ff", b_keep[1]); end
      if (b_last[1] !== 1'b1) begin bad++; $display("[TB] FAIL badb_last_bad: got %b want 1", b_last[1]); end
      if (b_data[2] !== word_of(8'd7, 16'd0)) begin bad++; $display("[TB] FAIL badb_data_good: got %h want %h", b_data[2], word_of(8'd7, 16'd0)); end
      if (b_keep[2] !== 8'hE0) begin bad++; $display("[TB] FAIL badb_keep_good: got %h want e0", b_keep[2]); end
      if (b_last[2] !== 1'b1) begin bad++; $display("[TB] FAIL badb_last_good: got %b want 1", b_last[2]); end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    reset_n = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(1);
    total += 2;
    if (error !== 1'b0) begin bad++; $display("[TB] FAIL ovr_reset_error: got %b want 0", error); end
    if (packets_sent !== 32'd0) begin bad++; $display("[TB] FAIL ovr_reset_sent: got %0d want 0", packets_sent); end
    clear_run();
    applyStimulus(6, 4'd8, 8'd8);
    wait_release(8, ok);
    wait_cycles(2);
    total += 5;
    if (!ok) begin bad++; $display("[TB] FAIL ovr_release: releases %0d want 8 (timeout)", pr_count); end
    if (b_data.size() != 4) begin bad++; $display("[TB] FAIL ovr_beats: got %0d want 4", b_data.size()); end
    if (error !== 1'b1) begin bad++; $display("[TB] FAIL ovr_error: got %b want 1", error); end
    if (packets_sent !== 32'd1) begin bad++; $display("[TB] FAIL ovr_sent: got %0d want 1", packets_sent); end
    if (reads_done != 4) begin bad++; $display("[TB] FAIL ovr_reads: got %0d want 4", reads_done); end
    for (int i = 0; i < 4 && i < b_data.size(); i++) begin
      total += 3;
      if (b_data[i] !== word_of(8'd8, 16'(i))) begin bad++; $display("[TB] FAIL ovr_data[%0d]: got %h want %h", i, b_data[i], word_of(8'd8, 16'(i))); end
      if (b_keep[i] !== 8'hFF) begin bad++; $display("[TB] FAIL ovr_keep[%0d]: got %h want ff", i, b_keep[i]); end
      if (b_last[i] !== (i == 3)) begin bad++; $display("[TB] FAIL ovr_last[%0d]: got %b want %b", i, b_last[i], (i == 3)); end
    end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    int pr_before;
    bit ok;
    clear_run();
    applyStimulus(6, 4'd8, 8'd9);
    n = 0;
    while ((b_data.size() < 1) && (n < 50)) begin
      wait_cycles(1);
      n++;
    end
    total++;
    if (b_data.size() < 1) begin bad++; $display("[TB] FAIL mid_first_beat: beats %0d want >= 1 (timeout)", b_data.size()); end
    pr_before = pr_count;
    reset_n = 1'b0;
    wait_cycles(1);
    total += 8;
    if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid: got %b want 0", tx_valid); end
    if (tx_data !== 64'd0) begin bad++; $display("[TB] FAIL mid_data: got %h want 0", tx_data); end
    if (tx_keep !== 8'd0) begin bad++; $display("[TB] FAIL mid_keep: got %h want 00", tx_keep); end
    if (tx_last !== 1'b0) begin bad++; $display("[TB] FAIL mid_last: got %b want 0", tx_last); end
    if (rd_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_rd_en: got %b want 0", rd_en); end
    if (packet_read !== 1'b0) begin bad++; $display("[TB] FAIL mid_packet_read: got %b want 0", packet_read); end
    if (error !== 1'b0) begin bad++; $display("[TB] FAIL mid_error: got %b want 0", error); end
    if (packets_sent !== 32'd0) begin bad++; $display("[TB] FAIL mid_sent: got %0d want 0", packets_sent); end
    wait_cycles(1);
    total++;
    if (pr_count != pr_before) begin bad++; $display("[TB] FAIL mid_no_release: releases %0d want %0d", pr_count, pr_before); end
    clear_run();
    reset_n = 1'b1;
    wait_release(pr_before + 1, ok);
    wait_cycles(2);
    total += 4;
    if (!ok) begin bad++; $display("[TB] FAIL mid_resend_release: releases %0d want %0d (timeout)", pr_count, pr_before + 1); end
    if (b_data.size() != 4) begin bad++; $display("[TB] FAIL mid_resend_beats: got %0d want 4", b_data.size()); end
    if (error !== 1'b1) begin bad++; $display("[TB] FAIL mid_resend_error: got %b want 1", error); end
    if (packets_sent !== 32'd1) begin bad++; $display("[TB] FAIL mid_resend_sent: got %0d want 1", packets_sent); end
    for (int i = 0; i < 4 && i < b_data.size(); i++) begin
      total += 2;
      if (b_data[i] !== word_of(8'd9, 16'(i))) begin bad++; $display("[TB] FAIL mid_resend_data[%0d]: got %h want %h", i, b_data[i], word_of(8'd9, 16'(i))); end
      if (b_last[i] !== (i == 3)) begin bad++; $display("[TB] FAIL mid_resend_last[%0d]: got %b want %b", i, b_last[i], (i == 3)); end
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    cycle       = 0;
    rd_ptr      = 0;
    pending_rd  = 1'b0;
    reads_done  = 0;
    ready_mode  = 0;
    pr_count    = 0;
    outstanding = 0;
    stall_prev  = 1'b0;
    stall_word  = '0;
    reset_n     = 1'b0;
    avail       = 1'b0;
    fifo_empty  = 1'b1;
    rd_data     = 64'd0;
    blw         = 4'd8;
    tx_ready    = 1'b1;
    clear_run();
    $display("[TB] starting nts_tx_mac_dispatcher bench");
    test_reset();
    test_basic();
    test_backpressure();
    test_single_word();
    test_back_to_back();
    test_bad_bytes();
    test_overrun();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
